// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand beat in, result beat out.
// The master drives operands and out_ready; the slave (the adder) drives the rest.
interface pipe_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic             cin;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in_sub, cin, in1, in2, out_ready,
        input  in_ready, out_valid, out, cout, overflow, zero
    );

    modport slave (
        input  in_valid, in_sub, cin, in1, in2, out_ready,
        output in_ready, out_valid, out, cout, overflow, zero
    );
endinterface

// File: rtl/pipe_adder.sv
// Skewed pipelined add/subtract: one SW-bit slice per stage, carry registered between stages.
// Define PIPE_ADDER_FLAGS_EN to build the registered overflow/zero flags; otherwise both read 0.
module pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4     // WIDTH must be a multiple of STAGES
) (
    input logic         clk,
    input logic         rst_n,
    pipe_adder_if.slave bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Stage registers: lower sum bits done, upper A/B' bits still waiting for their stage.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_nx [STAGES];

    always_comb begin
        logic [SW:0] sum;
        // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
        sum     = '0;
        vin[0]  = bus.in_valid;
        a_in[0] = bus.in1;
        b_in[0] = bus.in_sub ? ~bus.in2 : bus.in2;
        c_in[0] = bus.in_sub | bus.cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            vin[k]  = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                + {{SW{1'b0}}, c_in[k]};
            s_nx[k]              = s_in[k];
            s_nx[k][k*SW +: SW]  = sum[SW-1:0];
            c_nx[k]              = sum[SW];
        end
    end

    // A stage may load when it is empty or its own beat moves on; this ripples back from the consumer.
    always_comb begin
        logic [STAGES-1:0] ld;
        ld       = '0;
        ld[LAST] = !v_q[LAST] || bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
        load = ld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so out/cout read 0 straight after reset.
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= vin[k];
                    if (vin[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        s_q[k] <= s_nx[k];
                        c_q[k] <= c_nx[k];
                    end
                end
            end
        end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (load[LAST] && vin[LAST]) begin
            ovf_q  <= (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
                   && (s_nx[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
            zero_q <= (s_nx[LAST] == '0);
        end
    end

    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
`else
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
`endif

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v_q[LAST];
    assign bus.out       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=64, STAGES=4); expected flags follow PIPE_ADDER_FLAGS_EN.
// Inputs change just after the falling edge; handshakes and outputs are sampled 2 time units later.
module tb_pipe_adder;
    localparam int W = 64;
    localparam int S = 4;

    typedef struct {
        logic         sub;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } stim_t;

    typedef struct {
        logic [W-1:0] out;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();
    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    stim_t stim_q[$];
    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    stalls   = 0;
    bit    chk_lat  = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model(input stim_t s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        exp_t         e;
        bb     = s.sub ? ~s.b : s.b;
        full   = {1'b0, s.a} + {1'b0, bb} + {{W{1'b0}}, s.sub | s.cin};
        e.out  = full[W-1:0];
        e.cout = full[W];
`ifdef PIPE_ADDER_FLAGS_EN
        e.ovf  = (s.a[W-1] == bb[W-1]) && (e.out[W-1] != s.a[W-1]);
        e.zero = (e.out == '0);
`else
        e.ovf  = 1'b0;
        e.zero = 1'b0;
`endif
        e.acc  = cyc;
        return e;
    endfunction

    task automatic add_stim(input logic sub, input logic cin, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        stim_t s;
        s.sub = sub; s.cin = cin; s.a = a; s.b = b;
        stim_q.push_back(s);
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic step(input bit vld_en, input bit ordy);
        exp_t e;
        bus.out_ready = ordy;
        if (vld_en && stim_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_sub   = stim_q[0].sub;
            bus.cin      = stim_q[0].cin;
            bus.in1      = stim_q[0].a;
            bus.in2      = stim_q[0].b;
        end else begin
            bus.in_valid = 1'b0;
        end
        #2;
        check("in_ready", bus.in_ready, ordy || (sb_q.size() < S));
        if (sb_q.size() == 0) check("no_stale_valid", bus.out_valid, 1'b0);
        if (bus.in_valid && !bus.in_ready) stalls++;
        if (bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out", bus.out, e.out);
            check("cout", bus.cout, e.cout);
            check("overflow", bus.overflow, e.ovf);
            check("zero", bus.zero, e.zero);
            if (chk_lat) check("latency", cyc - e.acc, S);
        end
        if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(stim_q[0]));
            void'(stim_q.pop_front());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 64;
        while (sb_q.size() > 0 && budget > 0) begin
            step(1'b0, 1'b1);
            budget--;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic stream(input int vld_pct, input int rdy_pct);
        int budget = 2000;
        while (stim_q.size() > 0 && budget > 0) begin
            step($urandom_range(99) < vld_pct, $urandom_range(99) < rdy_pct);
            budget--;
        end
        check("stream_timeout", stim_q.size(), 0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        bus.cin       = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out", bus.out, '0);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_zero", bus.zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat into an empty pipe: wrap to zero, exact latency.
        chk_lat = 1'b1;
        add_stim(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        stream(100, 100);

        // Subtract cases and signed-overflow boundaries, back to back.
        add_stim(1'b1, 1'b0, 64'd5, 64'd7);
        add_stim(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1);
        add_stim(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        add_stim(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        stream(100, 100);

        // Backpressure: consumer stalls for cycles 2..9 of the stream.
        chk_lat = 1'b0;
        stalls  = 0;
        for (int i = 0; i < 10; i++) add_stim(1'b0, 1'b0, 64'(i), 64'(i));
        for (int j = 0; j < 200 && stim_q.size() > 0; j++) step(1'b1, !(j >= 2 && j <= 9));
        check("bp_stream_done", stim_q.size(), 0);
        drain();
        check("bp_in_ready_dropped", stalls != 0, 1'b1);

        // Full-rate random stream.
        chk_lat = 1'b1;
        for (int i = 0; i < 100; i++)
            add_stim(1'($urandom_range(1)), 1'($urandom_range(1)),
                     {$urandom, $urandom}, {$urandom, $urandom});
        stream(100, 100);

        // Random valid/ready gaps on both sides.
        chk_lat = 1'b0;
        for (int i = 0; i < 60; i++)
            add_stim(1'($urandom_range(1)), 1'($urandom_range(1)),
                     {$urandom, $urandom}, {$urandom, $urandom});
        stream(70, 60);

        // Reset with three beats in flight: they must never surface.
        for (int i = 0; i < 6; i++) add_stim(1'b0, 1'b0, 64'(100 + i), 64'd1);
        repeat (3) step(1'b1, 1'b0);
        check("inflight_before_reset", sb_q.size(), 3);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        sb_q.delete();
        stim_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (8) step(1'b0, 1'b1);
        chk_lat = 1'b1;
        add_stim(1'b1, 1'b0, 64'd0, 64'd0);
        stream(100, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
